// File: rtl/cmp_row_max_track.sv
// Row maximum tracker: folds a stream of (signed value, location) beats into
// one result per row (maximum, its location, beat count) and holds it until
// the downstream consumer takes it. A new row can start in the same cycle the
// held result is taken, so back-to-back rows need no idle cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on state and out_ready (never on in_valid);
// out_valid, once high, stays high with stable data until out_ready is 1.
module cmp_row_max_track #(
    parameter int CMP_WIDTH      = 16,
    parameter int LOCATION_WIDTH = 32,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic signed [CMP_WIDTH-1:0]   in_value,
    input  logic [LOCATION_WIDTH-1:0]     in_location,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [CMP_WIDTH-1:0]   out_max,
    output logic [LOCATION_WIDTH-1:0]     out_location,
    output logic [COUNT_WIDTH-1:0]        out_count,
    output logic                          err_first,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic signed [CMP_WIDTH-1:0] MAX_NEG  = {1'b1, {(CMP_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0]      CNT_MAX  = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]      CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]      CNT_ZERO = {COUNT_WIDTH{1'b0}};

    state_t                        state_q, state_d;
    logic signed [CMP_WIDTH-1:0]   best_q, best_d;
    logic [LOCATION_WIDTH-1:0]     loc_q, loc_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [CMP_WIDTH-1:0]   out_max_q, out_max_d;
    logic [LOCATION_WIDTH-1:0]     out_location_q, out_location_d;
    logic [COUNT_WIDTH-1:0]        out_count_q, out_count_d;
    logic                          err_q, err_d;

    logic                          accept;
    logic                          restart;
    logic signed [CMP_WIDTH-1:0]   row_best;
    logic [LOCATION_WIDTH-1:0]     row_loc;
    logic [COUNT_WIDTH-1:0]        row_count;

    // Ready/accept decode and the running row value after this cycle's beat.
    always_comb begin
        in_ready  = (state_q != ST_HOLD) || out_ready;
        accept    = in_valid && in_ready;
        // Outside ACCUM every beat opens a row; inside ACCUM only a first beat.
        restart   = (state_q != ST_ACCUM) || in_first;
        row_best  = best_q;
        row_loc   = loc_q;
        row_count = count_q;
        if (restart) begin
            row_best  = in_value;
            row_loc   = in_location;
            row_count = CNT_ONE;
        end else begin
            // Strict compare: a tie keeps the earlier location.
            if (in_value > best_q) begin
                row_best = in_value;
                row_loc  = in_location;
            end
            row_count = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);
        end
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d        = state_q;
        best_d         = best_q;
        loc_d          = loc_q;
        count_d        = count_q;
        out_valid_d    = out_valid_q;
        out_max_d      = out_max_q;
        out_location_d = out_location_q;
        out_count_d    = out_count_q;
        err_d          = err_q;

        if (clear) begin
            // Abort: any beat this cycle is dropped, err_first is kept.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            count_d     = CNT_ZERO;
            out_count_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid_d = 1'b0;
                end
                ST_ACCUM: begin
                    out_valid_d = 1'b0;
                    if (accept && in_first) begin
                        err_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase

            if (accept) begin
                best_d  = row_best;
                loc_d   = row_loc;
                count_d = row_count;
                if (in_last) begin
                    state_d        = ST_HOLD;
                    out_valid_d    = 1'b1;
                    out_max_d      = row_best;
                    out_location_d = row_loc;
                    out_count_d    = row_count;
                end else begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    // State registers; reset wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            best_q         <= MAX_NEG;
            loc_q          <= '0;
            count_q        <= CNT_ZERO;
            out_valid_q    <= 1'b0;
            out_max_q      <= MAX_NEG;
            out_location_q <= '0;
            out_count_q    <= CNT_ZERO;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            best_q         <= best_d;
            loc_q          <= loc_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_max_q      <= out_max_d;
            out_location_q <= out_location_d;
            out_count_q    <= out_count_d;
            err_q          <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_max      = out_max_q;
    assign out_location = out_location_q;
    assign out_count    = out_count_q;
    assign err_first    = err_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/cmp_row_max_track.md
CMP_ROW_MAX_TRACK -- requirements
Module: cmp_row_max_track

Interface
REQ-001 SHALL have parameter CMP_WIDTH, default 16, signed score width.
REQ-002 SHALL have parameter LOCATION_WIDTH, default 32, location tag width.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, beat-count width.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 clear  in  1  synchronous abort of the current row.
REQ-007 in_valid  in  1  upstream beat valid; carries the column-compare max/location pair.
REQ-008 in_ready  out  1  the block accepts the beat this cycle.
REQ-009 in_first  in  1  beat opens a row.
REQ-010 in_last  in  1  beat closes a row.
REQ-011 in_value  in  CMP_WIDTH  signed column maximum.
REQ-012 in_location  in  LOCATION_WIDTH  location tag of in_value.
REQ-013 out_valid  out  1  row result available.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_max  out  CMP_WIDTH  signed row maximum.
REQ-016 out_location  out  LOCATION_WIDTH  location of out_max.
REQ-017 out_count  out  COUNT_WIDTH  beats accepted in the row.
REQ-018 err_first  out  1  sticky protocol-error flag.

Function
REQ-019 A beat SHALL be accepted only when in_valid and in_ready are both 1.
REQ-020 The FSM SHALL have the states IDLE, ACCUM and HOLD.
REQ-021 IDLE: in_ready=1, out_valid=0. An accepted beat loads best=in_value, loc=in_location, count=1, and treats in_first as implied. The next state is HOLD if in_last=1, else ACCUM.
REQ-022 ACCUM: in_ready=1. An accepted beat with in_value > best (signed, strict) replaces best and loc; ties keep the earlier beat. count increments. in_last=1 leads to HOLD.
REQ-023 ACCUM with an accepted in_first=1 beat SHALL discard the partial row, reload as in REQ-021 and set err_first.
REQ-024 count SHALL saturate at all-ones and never wrap.
REQ-025 HOLD: out_valid=1, and out_max/out_location/out_count SHALL be stable until the handshake; in_ready=out_ready.
REQ-026 HOLD with out_ready=1 and no accepted beat SHALL go to IDLE the next cycle.
REQ-027 HOLD with out_ready=1 and an accepted beat SHALL reload per REQ-021 in the same cycle (zero-bubble): the next state is HOLD if that beat has in_last=1, else ACCUM.
REQ-028 A beat with in_first=1 and in_last=1 SHALL form a one-beat row with count=1.
REQ-029 Latency: out_valid SHALL rise the cycle after the in_last beat is accepted.
REQ-030 All outputs SHALL be registered, except in_ready, which is decoded combinationally from state and out_ready.
REQ-031 clear=1 SHALL force IDLE, out_valid=0 and count=0 the next cycle, ignore any beat in that cycle, and leave err_first unchanged.
REQ-032 When rst and clear are both 1, rst SHALL take priority.

Reset
REQ-033 rst=1 SHALL set state=IDLE, out_valid=0, out_max=most-negative value (16'sh8000 at default), out_location=0, out_count=0 and err_first=0.
REQ-034 Reset asserted mid-row or in HOLD SHALL drop the row with no result emitted.
REQ-035 err_first SHALL clear only on rst.

Verification
REQ-036 Row of values 5,-3,9,9,2 at locations 10..14 with out_ready=1 -> one result: max=9, loc=12, count=5, out_valid exactly one cycle after the last beat.
REQ-037 Single beat first=last=1, value=-32768, loc=7 -> max=-32768, loc=7, count=1.
REQ-038 out_ready=0 for 4 cycles in HOLD with in_valid=1 -> in_ready=0 and outputs stable. Then raising out_ready while a next first=last beat (value 4) is pending -> result accepted, and the new result (value 4) is valid the next cycle with no bubble.
REQ-039 in_first=1 mid-row after 3 beats -> err_first=1; the result covers only the restarted row; err_first stays 1 after further rows.
REQ-040 clear asserted in ACCUM and, separately, in HOLD -> IDLE next cycle, out_valid=0, no result; rst asserted simultaneously with clear -> all reset values per REQ-033.
REQ-041 2^16+3 beats with COUNT_WIDTH=16 -> out_count=16'hFFFF.
